// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing the single-ported DataMemory between the
// CPU MEM stage (requester 0) and the loader/debug DMA port (requester 1).
module data_mem_arbiter (
    input  logic        Clock,
    input  logic        Reset,

    input  logic        Req0,
    input  logic        We0,
    input  logic [1:0]  Cmd0,
    input  logic        Unsigned0,
    input  logic [31:0] Addr0,
    input  logic [31:0] WData0,
    output logic        Gnt0,
    output logic        Ack0,
    output logic        Err0,
    output logic [31:0] RData0,

    input  logic        Req1,
    input  logic        We1,
    input  logic [1:0]  Cmd1,
    input  logic        Unsigned1,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData1,
    output logic        Gnt1,
    output logic        Ack1,
    output logic        Err1,
    output logic [31:0] RData1,

    output logic        Mem_R_en,
    output logic        Mem_W_en,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_W_data,
    output logic [1:0]  Mem_ReadCommand,
    output logic [1:0]  Mem_WriteCommand,
    input  logic [31:0] Mem_R_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic [1:0] CmdWord = 2'd0;
    localparam logic [1:0] CmdHalf = 2'd1;
    localparam logic [1:0] CmdByte = 2'd2;

    state_e      r_state, w_state_next;
    logic        r_last, r_sel, r_we, r_uns, r_legal;
    logic [1:0]  r_cmd;
    logic [31:0] r_addr, r_wdata;

    logic        w_any, w_win, w_arb, w_legal;
    logic        w_we, w_uns;
    logic [1:0]  w_cmd;
    logic [31:0] w_addr, w_wdata;
    logic        w_mem_on, w_ack, w_err;
    logic [31:0] w_ext;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        w_any   = Req0 | Req1;
        w_win   = (Req0 && Req1) ? ~r_last : Req1;
        w_we    = w_win ? We1       : We0;
        w_cmd   = w_win ? Cmd1      : Cmd0;
        w_uns   = w_win ? Unsigned1 : Unsigned0;
        w_addr  = w_win ? Addr1     : Addr0;
        w_wdata = w_win ? WData1    : WData0;
        w_arb   = (r_state != StIssue) && w_any;
        case (w_cmd)
            CmdWord: w_legal = (w_addr[1:0] == 2'b00);
            CmdHalf: w_legal = ~w_addr[0];
            CmdByte: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  w_state_next = w_any ? StIssue : StIdle;
            StIssue: w_state_next = StResp;
            StResp:  w_state_next = w_any ? StIssue : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_cmd   <= 2'd0;
            r_uns   <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_legal <= 1'b0;
        end else if (w_arb) begin
            r_last  <= w_win;
            r_sel   <= w_win;
            r_we    <= w_we;
            r_cmd   <= w_cmd;
            r_uns   <= w_uns;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_legal <= w_legal;
        end
    end

    // Load data arrives right-aligned; only the extension is done here.
    always_comb begin
        case (r_cmd)
            CmdWord: w_ext = Mem_R_data;
            CmdHalf: w_ext = r_uns ? {16'h0, Mem_R_data[15:0]}
                                   : {{16{Mem_R_data[15]}}, Mem_R_data[15:0]};
            CmdByte: w_ext = r_uns ? {24'h0, Mem_R_data[7:0]}
                                   : {{24{Mem_R_data[7]}}, Mem_R_data[7:0]};
            default: w_ext = 32'h0;
        endcase
    end

    always_comb begin
        w_mem_on         = (r_state == StIssue) && r_legal;
        w_ack            = (r_state == StResp) && r_legal;
        w_err            = (r_state == StResp) && !r_legal;

        Gnt0             = (r_state == StIssue) && !r_sel;
        Gnt1             = (r_state == StIssue) && r_sel;
        Ack0             = w_ack && !r_sel;
        Ack1             = w_ack && r_sel;
        Err0             = w_err && !r_sel;
        Err1             = w_err && r_sel;
        RData0           = (w_ack && !r_we && !r_sel) ? w_ext : 32'h0;
        RData1           = (w_ack && !r_we && r_sel) ? w_ext : 32'h0;

        Mem_R_en         = w_mem_on && !r_we;
        Mem_W_en         = w_mem_on && r_we;
        Mem_Address      = w_mem_on ? r_addr : 32'h0;
        Mem_W_data       = w_mem_on ? r_wdata : 32'h0;
        Mem_ReadCommand  = w_mem_on ? r_cmd : 2'd0;
        Mem_WriteCommand = w_mem_on ? r_cmd : 2'd0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: per-port request queues, a behavioural DataMemory and a
// cycle model of grant/response timing that predicts what the arbiter must produce.
module tb_data_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req0, We0, Unsigned0, Req1, We1, Unsigned1;
    logic [1:0]  Cmd0, Cmd1;
    logic [31:0] Addr0, WData0, Addr1, WData1;
    logic        Gnt0, Ack0, Err0, Gnt1, Ack1, Err1;
    logic [31:0] RData0, RData1;
    logic        Mem_R_en, Mem_W_en;
    logic [31:0] Mem_Address, Mem_W_data;
    logic [1:0]  Mem_ReadCommand, Mem_WriteCommand;
    logic [31:0] Mem_R_data = 32'h0;

    always #5 Clock = ~Clock;

    data_mem_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Cmd0(Cmd0), .Unsigned0(Unsigned0), .Addr0(Addr0),
        .WData0(WData0), .Gnt0(Gnt0), .Ack0(Ack0), .Err0(Err0), .RData0(RData0),
        .Req1(Req1), .We1(We1), .Cmd1(Cmd1), .Unsigned1(Unsigned1), .Addr1(Addr1),
        .WData1(WData1), .Gnt1(Gnt1), .Ack1(Ack1), .Err1(Err1), .RData1(RData1),
        .Mem_R_en(Mem_R_en), .Mem_W_en(Mem_W_en), .Mem_Address(Mem_Address),
        .Mem_W_data(Mem_W_data), .Mem_ReadCommand(Mem_ReadCommand),
        .Mem_WriteCommand(Mem_WriteCommand), .Mem_R_data(Mem_R_data)
    );

    // Behavioural DataMemory: bytes big-endian within a word, halves selected by Addr[1].
    logic [31:0] mem [0:63] = '{8: 32'h12345678, default: 32'h0};

    function automatic int lane_sh(input logic [1:0] cmd, input logic [1:0] a);
        case (cmd)
            2'd1:    return a[1] ? 16 : 0;
            2'd2:    return (3 - int'(a)) * 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] cmd);
        case (cmd)
            2'd1:    return 32'h0000ffff;
            2'd2:    return 32'h000000ff;
            default: return 32'hffffffff;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (Mem_W_en)
            mem[Mem_Address[7:2]] <= (mem[Mem_Address[7:2]] &
                ~(lane_mask(Mem_WriteCommand) << lane_sh(Mem_WriteCommand, Mem_Address[1:0]))) |
                ((Mem_W_data & lane_mask(Mem_WriteCommand))
                    << lane_sh(Mem_WriteCommand, Mem_Address[1:0]));
        if (Mem_R_en)
            Mem_R_data <= (mem[Mem_Address[7:2]] >> lane_sh(Mem_ReadCommand, Mem_Address[1:0]))
                          & lane_mask(Mem_ReadCommand);
    end

    typedef struct packed {
        logic        we;
        logic [1:0]  cmd;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } op_t;

    typedef struct packed {
        logic        port;
        logic        err;
        logic        load;
        logic [31:0] rdata;
    } exp_t;

    op_t  q0[$], q1[$];
    exp_t sb[$];
    int   glog[$];
    logic m_issue, m_resp, m_last, m_win;
    int   n_vec, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [1:0] cmd, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata);
        op_t o;
        o.we = we; o.cmd = cmd; o.uns = uns; o.addr = addr; o.wdata = wdata;
        o.err = err; o.rdata = rdata;
        return o;
    endfunction

    // One cycle: check outputs at the falling edge, then drive and predict the next cycle.
    task automatic tick();
        op_t  op;
        exp_t e;
        logic legal;
        @(negedge Clock);
        check("gnt", {Gnt1, Gnt0}, {m_issue && m_win, m_issue && !m_win});
        if (Gnt0 || Gnt1) glog.push_back(Gnt1 ? 1 : 0);
        if (m_issue) begin
            if (m_win) op = q1.pop_front();
            else       op = q0.pop_front();
            legal = !op.err;
            check("mem_en", {Mem_R_en, Mem_W_en}, {legal && !op.we, legal && op.we});
            check("mem_addr", Mem_Address, legal ? op.addr : 32'h0);
            check("mem_cmd", {Mem_ReadCommand, Mem_WriteCommand}, legal ? {op.cmd, op.cmd} : 4'h0);
            check("mem_wdata", Mem_W_data, legal ? op.wdata : 32'h0);
            e.port = m_win; e.err = op.err; e.load = !op.we; e.rdata = op.rdata;
            sb.push_back(e);
        end else begin
            check("mem_quiet", {Mem_R_en, Mem_W_en, Mem_ReadCommand, Mem_WriteCommand,
                                Mem_Address}, 64'h0);
        end
        if (m_resp) begin
            e = sb.pop_front();
            check("resp", {Ack1, Ack0, Err1, Err0},
                  {e.port && !e.err, !e.port && !e.err, e.port && e.err, !e.port && e.err});
            check("rdata0", RData0, (!e.port && !e.err && e.load) ? e.rdata : 32'h0);
            check("rdata1", RData1, (e.port && !e.err && e.load) ? e.rdata : 32'h0);
        end else begin
            check("no_resp", {Ack1, Ack0, Err1, Err0}, 4'h0);
        end

        Req0 = q0.size() != 0;
        if (Req0) begin
            We0 = q0[0].we; Cmd0 = q0[0].cmd; Unsigned0 = q0[0].uns;
            Addr0 = q0[0].addr; WData0 = q0[0].wdata;
        end
        Req1 = q1.size() != 0;
        if (Req1) begin
            We1 = q1[0].we; Cmd1 = q1[0].cmd; Unsigned1 = q1[0].uns;
            Addr1 = q1[0].addr; WData1 = q1[0].wdata;
        end

        m_resp = m_issue;
        if (!m_issue && (Req0 || Req1)) begin
            m_win   = (Req0 && Req1) ? !m_last : Req1;
            m_last  = m_win;
            m_issue = 1'b1;
        end else begin
            m_issue = 1'b0;
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_issue || m_resp) && n < max) begin
            tick();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0 || m_issue || m_resp) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: traffic still pending after %0d cycles", max);
        end
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_issue = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_win = 1'b0;
        Reset = 1'b0;
        Req0 = 0; We0 = 0; Cmd0 = 0; Unsigned0 = 0; Addr0 = 0; WData0 = 0;
        Req1 = 0; We1 = 0; Cmd1 = 0; Unsigned1 = 0; Addr1 = 0; WData1 = 0;
        @(negedge Clock);
        @(negedge Clock);
        check("rst_ctl", {Gnt0, Gnt1, Ack0, Ack1, Err0, Err1, Mem_R_en, Mem_W_en,
                          Mem_ReadCommand, Mem_WriteCommand}, 64'h0);
        check("rst_mem", {Mem_Address, Mem_W_data}, 64'h0);
        check("rst_rdata", {RData0, RData1}, 64'h0);
        Reset = 1'b1;

        // Word store, then word and sub-word loads of the same location.
        q0.push_back(mk(1, 2'd0, 0, 32'h10, 32'hdeadbeef, 0, 32'h0));
        q0.push_back(mk(0, 2'd0, 0, 32'h10, 32'h0, 0, 32'hdeadbeef));
        q0.push_back(mk(0, 2'd1, 0, 32'h10, 32'h0, 0, 32'hffffbeef));
        q0.push_back(mk(0, 2'd1, 1, 32'h10, 32'h0, 0, 32'h0000beef));
        q0.push_back(mk(0, 2'd2, 0, 32'h13, 32'h0, 0, 32'hffffffef));
        q0.push_back(mk(0, 2'd2, 1, 32'h12, 32'h0, 0, 32'h000000be));
        run(40);

        // Misaligned and illegal accesses, then readback of 0x10 from requester 1.
        q0.push_back(mk(0, 2'd0, 0, 32'h11, 32'h0, 1, 32'h0));
        q0.push_back(mk(1, 2'd1, 0, 32'h13, 32'h1234, 1, 32'h0));
        q0.push_back(mk(0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0));
        run(30);
        q1.push_back(mk(0, 2'd0, 0, 32'h10, 32'h0, 0, 32'hdeadbeef));
        run(10);

        // Both requesters asserting continuously: grants alternate starting with 0.
        glog.delete();
        q0.push_back(mk(1, 2'd0, 0, 32'h40, 32'h11223344, 0, 32'h0));
        q0.push_back(mk(0, 2'd0, 0, 32'h40, 32'h0, 0, 32'h11223344));
        q0.push_back(mk(0, 2'd1, 0, 32'h42, 32'h0, 0, 32'h00001122));
        q1.push_back(mk(1, 2'd0, 0, 32'h44, 32'h8899aabb, 0, 32'h0));
        q1.push_back(mk(0, 2'd0, 0, 32'h44, 32'h0, 0, 32'h8899aabb));
        q1.push_back(mk(0, 2'd2, 0, 32'h44, 32'h0, 0, 32'hffffff88));
        run(40);
        check("alt_cnt", glog.size(), 6);
        for (int k = 0; k < glog.size() && k < 6; k++) check("alt", glog[k], k % 2);

        // Reset during ISSUE of a store to 0x20 abandons it.
        q0.push_back(mk(1, 2'd0, 0, 32'h20, 32'hcafef00d, 0, 32'h0));
        tick();
        tick();
        #1 Reset = 1'b0;
        #1;
        check("rst_wen", Mem_W_en, 1'b0);
        check("rst_gnt", {Gnt0, Gnt1}, 2'b00);
        sb.delete();
        m_issue = 1'b0; m_resp = 1'b0; m_last = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) tick();

        // Next tie after reset goes to requester 0; 0x20 keeps its old contents.
        glog.delete();
        q0.push_back(mk(0, 2'd0, 0, 32'h20, 32'h0, 0, 32'h12345678));
        q1.push_back(mk(0, 2'd0, 0, 32'h10, 32'h0, 0, 32'hdeadbeef));
        run(20);
        check("tie_cnt", glog.size(), 2);
        if (glog.size() > 0) check("tie_after_rst", glog[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the single-ported `DataMemory`. It shares the memory between requester 0 (CPU MEM stage) and requester 1 (loader/debug DMA port) using round-robin arbitration. It drives the memory's enables, address, data and size commands, and checks alignment. It also sign- or zero-extends sub-word load data before returning it to the winning requester.

## Interface
Parameters: none. Widths are fixed at 32-bit data/address and 2-bit command. Ports marked N are duplicated for N = 0 and N = 1.
- `Clock` in 1: single clock; everything is rising-edge.
- `Reset` in 1: asynchronous, active-low reset.
- `ReqN` in 1: requester N has an access pending; held until `GntN` is seen.
- `WeN` in 1: 1 = store, 0 = load.
- `CmdN` in 2: size code, 0 = word, 1 = half, 2 = byte, 3 = illegal.
- `UnsignedN` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `AddrN` in 32: byte address.
- `WDataN` in 32: store data, right-aligned.
- `GntN` out 1: one-cycle pulse; the request fields were captured.
- `AckN` out 1: one-cycle pulse; the access completed.
- `ErrN` out 1: one-cycle pulse; the access was rejected as misaligned or illegal.
- `RDataN` out 32: extended load data, valid only while `AckN` is high on a load; 0 otherwise.
- `Mem_R_en`, `Mem_W_en` out 1: memory enables.
- `Mem_Address` out 32: memory address.
- `Mem_W_data` out 32: memory write data.
- `Mem_ReadCommand`, `Mem_WriteCommand` out 2: memory size commands.
- `Mem_R_data` in 32: memory read data, registered inside the memory on the enabled edge.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE: if any `ReqN` is high, arbitrate, capture the winner's fields into internal registers, and go to ISSUE. Otherwise stay in IDLE.
- Arbitration: if only one requester is asserting, it wins. If both are asserting, the requester not granted last time wins. The `Last` register resets to 1, so requester 0 wins the first tie.
- ISSUE: `GntN` is high for the captured requester.
  - Legal access: `Mem_R_en = !We` or `Mem_W_en = We`, `Mem_Address`, `Mem_W_data` and both commands driven from the captured registers. All memory outputs come from registers.
  - Illegal access: both enables stay 0. Next state is always RESP.
- Legality rules:
  - `Cmd = 3` is illegal.
  - Word with `Addr[1:0] != 0` is illegal.
  - Half with `Addr[0] != 0` is illegal.
  - Byte is always legal.
- RESP, legal access: `AckN` = 1.
- RESP, illegal access: `ErrN` = 1.
- RESP, load result in `RDataN`:
  - Word: `Mem_R_data` unchanged.
  - Half: bits [15:0], extended by `Unsigned`.
  - Byte: bits [7:0], extended by `Unsigned`.
- RESP also arbitrates exactly as IDLE does. If any request is present, go to ISSUE; otherwise go to IDLE. The requester must drop or replace its `Req` in the cycle after `Gnt`, so the values sampled in RESP are fresh.
- `Last` updates at the IDLE/RESP→ISSUE edge to the winner's index.
- Memory-side outputs are 0 in every state except a legal ISSUE.

## Timing
- Reset values: state IDLE, `Last` = 1. All `Gnt`, `Ack`, `Err`, `RData`, `Mem_*` outputs are 0.
- Reset is asynchronous. Asserting it mid-access abandons the access and clears `Mem_W_en` immediately, so no write happens at any edge while `Reset` is low. There is no `Ack` for an abandoned access.
- Request-to-response latency: `Req` is sampled at edge E0. `Gnt` and the memory enables are high in cycle E0→E1. The memory acts at E1. `Ack`/`Err` and `RData` are valid in cycle E1→E2.
- Throughput: one access per 2 cycles under back-to-back requests. Consecutive grants alternate when both requesters stay asserted.
- A store followed by a load to the same word returns the new data, because the write completes at E1 and the next read is issued no earlier than E3.
- `Gnt`, `Ack` and `Err` are never high for both requesters in the same cycle. `Ack` and `Err` are never high together.

## Test plan
- Reset release with Req0 only: store word `0xDEADBEEF` to 0x10. Expect Gnt0 in cycle 2 with `Mem_W_en` = 1 and `Mem_Address` = 0x10, then Ack0 in cycle 3. Then load word from 0x10 and expect Ack0 with RData0 = `0xDEADBEEF`.
- Sub-word extension after the store above:
  - Half from 0x10, signed → `0xFFFFBEEF`; unsigned → `0x0000BEEF`.
  - Byte from 0x13, signed → `0xFFFFFFEF`.
  - Byte from 0x12, unsigned → `0x000000BE`.
- Both requesters asserting continuously: grants go 0, 1, 0, 1 on alternate cycles. Each Ack arrives one cycle after its Gnt with no overlap.
- Misaligned and illegal accesses: word at 0x11, half at 0x13, and Cmd = 3 each produce Gnt, then Err. Memory enables stay 0 throughout, and a readback of 0x10 is unchanged.
- Reset asserted during ISSUE of a store to 0x20: `Mem_W_en` drops asynchronously, no Ack is produced, and a later load of 0x20 returns its pre-test value. After reset, the next tie is won by requester 0.
